// File: rtl/di_host_arbiter.sv
// di_host_arbiter: two-requester arbiter for a shared device interface bus.
// The owner's transaction signals are passed through combinationally; round-robin
// picks the winner on simultaneous requests, and an owner that holds the bus too
// long is forced off and flagged.
//
// state | meaning
// IDLE  | no owner, device strobes low, next owner chosen here
// OWN_A | requester A drives the device bus
// OWN_B | requester B drives the device bus
// TURN  | one dead cycle between owners, device strobes low
module di_host_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        ifclk,
    input  logic        resetb,

    input  logic [15:0] a_term_addr,
    input  logic [31:0] a_reg_addr,
    input  logic [31:0] a_len,
    input  logic [31:0] a_reg_datai,
    input  logic        a_read_mode,
    input  logic        a_read_req,
    input  logic        a_read,
    input  logic        a_write_mode,
    input  logic        a_write,
    output logic        a_read_rdy,
    output logic        a_write_rdy,
    output logic [31:0] a_reg_datao,
    output logic [15:0] a_transfer_status,

    input  logic [15:0] b_term_addr,
    input  logic [31:0] b_reg_addr,
    input  logic [31:0] b_len,
    input  logic [31:0] b_reg_datai,
    input  logic        b_read_mode,
    input  logic        b_read_req,
    input  logic        b_read,
    input  logic        b_write_mode,
    input  logic        b_write,
    output logic        b_read_rdy,
    output logic        b_write_rdy,
    output logic [31:0] b_reg_datao,
    output logic [15:0] b_transfer_status,

    output logic [15:0] di_term_addr,
    output logic [31:0] di_reg_addr,
    output logic [31:0] di_len,
    output logic [31:0] di_reg_datai,
    output logic        di_read_mode,
    output logic        di_read_req,
    output logic        di_read,
    output logic        di_write_mode,
    output logic        di_write,
    input  logic        di_read_rdy,
    input  logic        di_write_rdy,
    input  logic [31:0] di_reg_datao,
    input  logic [15:0] di_transfer_status,

    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        timeout_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;      // 1: B was granted most recently
    logic              inelig_a_q, inelig_a_d;
    logic              inelig_b_q, inelig_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              ready_q;                 // blocks granting on the first edge after reset release
    logic [31:0]       a_datao_q, a_datao_d, b_datao_q, b_datao_d;
    logic [15:0]       a_status_q, a_status_d, b_status_q, b_status_d;

    logic req_a, req_b, elig_a, elig_b;
    logic timeout_a, timeout_b;

    assign req_a  = a_read_mode | a_write_mode;
    assign req_b  = b_read_mode | b_write_mode;
    assign elig_a = req_a & ~inelig_a_q;
    assign elig_b = req_b & ~inelig_b_q;

    assign timeout_a = (state_q == OWN_A) && req_a && (cnt_q == CNT_LAST);
    assign timeout_b = (state_q == OWN_B) && req_b && (cnt_q == CNT_LAST);

    // Next-state, hold counter and round-robin bookkeeping
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ready_q) begin
                    if (elig_a && (!elig_b || last_b_q)) begin
                        state_d  = OWN_A;
                        last_b_d = 1'b0;
                    end else if (elig_b) begin
                        state_d  = OWN_B;
                        last_b_d = 1'b1;
                    end
                end
            end
            OWN_A: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (!req_a || timeout_a) state_d = TURN;
            end
            OWN_B: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (!req_b || timeout_b) state_d = TURN;
            end
            TURN: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky error, lockout flags and per-requester held return values
    always_comb begin
        timeout_err_d = timeout_err_q;
        if (timeout_a || timeout_b) timeout_err_d = 1'b1;
        else if (timeout_clr)       timeout_err_d = 1'b0;

        inelig_a_d = inelig_a_q;
        if (timeout_a)   inelig_a_d = 1'b1;
        else if (!req_a) inelig_a_d = 1'b0;

        inelig_b_d = inelig_b_q;
        if (timeout_b)   inelig_b_d = 1'b1;
        else if (!req_b) inelig_b_d = 1'b0;

        a_datao_d  = (state_q == OWN_A) ? di_reg_datao       : a_datao_q;
        a_status_d = (state_q == OWN_A) ? di_transfer_status : a_status_q;
        b_datao_d  = (state_q == OWN_B) ? di_reg_datao       : b_datao_q;
        b_status_d = (state_q == OWN_B) ? di_transfer_status : b_status_q;
    end

    // State and bookkeeping registers
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= IDLE;
            last_b_q      <= 1'b1;
            inelig_a_q    <= 1'b0;
            inelig_b_q    <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            ready_q       <= 1'b0;
            a_datao_q     <= '0;
            a_status_q    <= '0;
            b_datao_q     <= '0;
            b_status_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_b_q      <= last_b_d;
            inelig_a_q    <= inelig_a_d;
            inelig_b_q    <= inelig_b_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            ready_q       <= 1'b1;
            a_datao_q     <= a_datao_d;
            a_status_q    <= a_status_d;
            b_datao_q     <= b_datao_d;
            b_status_q    <= b_status_d;
        end
    end

    // Output steering: owner's signals pass straight through, everything else idles
    always_comb begin
        di_term_addr      = '0;
        di_reg_addr       = '0;
        di_len            = '0;
        di_reg_datai      = '0;
        di_read_mode      = 1'b0;
        di_read_req       = 1'b0;
        di_read           = 1'b0;
        di_write_mode     = 1'b0;
        di_write          = 1'b0;
        a_read_rdy        = 1'b0;
        a_write_rdy       = 1'b0;
        b_read_rdy        = 1'b0;
        b_write_rdy       = 1'b0;
        a_reg_datao       = a_datao_q;
        a_transfer_status = a_status_q;
        b_reg_datao       = b_datao_q;
        b_transfer_status = b_status_q;
        case (state_q)
            OWN_A: begin
                di_term_addr      = a_term_addr;
                di_reg_addr       = a_reg_addr;
                di_len            = a_len;
                di_reg_datai      = a_reg_datai;
                di_read_mode      = a_read_mode;
                di_read_req       = a_read_req;
                di_read           = a_read;
                di_write_mode     = a_write_mode;
                di_write          = a_write;
                a_read_rdy        = di_read_rdy;
                a_write_rdy       = di_write_rdy;
                a_reg_datao       = di_reg_datao;
                a_transfer_status = di_transfer_status;
            end
            OWN_B: begin
                di_term_addr      = b_term_addr;
                di_reg_addr       = b_reg_addr;
                di_len            = b_len;
                di_reg_datai      = b_reg_datai;
                di_read_mode      = b_read_mode;
                di_read_req       = b_read_req;
                di_read           = b_read;
                di_write_mode     = b_write_mode;
                di_write          = b_write;
                b_read_rdy        = di_read_rdy;
                b_write_rdy       = di_write_rdy;
                b_reg_datao       = di_reg_datao;
                b_transfer_status = di_transfer_status;
            end
            default: ;
        endcase
    end

    assign grant       = {state_q == OWN_B, state_q == OWN_A};
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/di_host_arbiter.md
DI_HOST_ARBITER -- requirements
Module: di_host_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum cycles one requester may hold the device interface.
REQ-002 SHALL have parameter CNT_W, default 16, width of the timeout counter.
REQ-003 ifclk  input  1  clock; all logic on rising edge.
REQ-004 resetb  input  1  reset, asynchronous, active-low.
REQ-005 a_term_addr/b_term_addr  input  16  per-requester terminal address.
REQ-006 a_reg_addr/b_reg_addr, a_len/b_len, a_reg_datai/b_reg_datai  input  32 each  per-requester register address, length, write data.
REQ-007 a_read_mode, a_read_req, a_read, a_write_mode, a_write (and b_ equivalents)  input  1 each  per-requester transaction strobes.
REQ-008 a_read_rdy, a_write_rdy (and b_)  output  1 each  rdy returned to each requester.
REQ-009 a_reg_datao/b_reg_datao  output  32; a_transfer_status/b_transfer_status  output  16  returned data and status.
REQ-010 di_term_addr 16, di_reg_addr 32, di_len 32, di_reg_datai 32, di_read_mode, di_read_req, di_read, di_write_mode, di_write 1 each  output  shared device-side bus.
REQ-011 di_read_rdy, di_write_rdy 1, di_reg_datao 32, di_transfer_status 16  input  device responses.
REQ-012 grant  output  2  one-hot owner {b,a}; 00 = none.
REQ-013 timeout_err  output  1  sticky flag, set on forced release.
REQ-014 timeout_clr  input  1  synchronous clear of timeout_err.

Function
REQ-015 Requester X requests when X_read_mode|X_write_mode = 1 (req_X).
REQ-016 States: IDLE, OWN_A, OWN_B, TURN; state register only source of grant.
REQ-017 IDLE: req_A only -> OWN_A; req_B only -> OWN_B; both -> requester not last granted; neither -> stay.
REQ-018 last_owner register updates on every IDLE->OWN_x transition; reset value selects B, so A wins first simultaneous request.
REQ-019 OWN_x: stays while req_x = 1; req_x = 0 -> TURN.
REQ-020 TURN: one cycle, all device strobes 0, then IDLE unconditionally.
REQ-021 Grant latency: request seen in cycle N in IDLE -> grant and device strobes forwarded in cycle N+1.
REQ-022 OWN_x: all di_* outputs combinationally equal requester x inputs; x_read_rdy/x_write_rdy = di_read_rdy/di_write_rdy; x_reg_datao, x_transfer_status = device values.
REQ-023 Non-owner and all requesters in IDLE/TURN: rdy outputs 0; reg_datao and transfer_status hold last value registered while that requester owned the bus.
REQ-024 IDLE/TURN: di_read_mode, di_read_req, di_read, di_write_mode, di_write = 0; address/data outputs = 0.
REQ-025 Timeout counter CNT_W bits: cleared on entry to OWN_x, +1 per OWN_x cycle, saturates, no wrap.
REQ-026 Counter reaching TIMEOUT_CYCLES-1 while req_x still 1 -> TURN, timeout_err <= 1; x then ineligible until req_x has been 0 for at least one cycle.
REQ-027 timeout_clr and timeout set same cycle -> set wins.
REQ-028 Requester dropping its mode mid-transfer is not an error; arbiter releases per REQ-019, no beat completion forced.
REQ-029 Non-owner's request held while other owns; served next IDLE, no request lost.

Reset
REQ-030 resetb low: state IDLE, grant 00, counter 0, timeout_err 0, last_owner B, ineligible flags 0, held datao/status 0, all di_* strobes 0, all rdy 0.
REQ-031 Reset asserted mid-transfer aborts immediately; no strobe emitted after resetb falls.
REQ-032 First grant possible in the second rising edge after resetb rises.

Verification
REQ-033 A read_mode=1 alone from IDLE -> grant=01 next cycle; di_reg_addr follows a_reg_addr; a_reg_datao=0x12345678 when device returns it with di_read.
REQ-034 A and B request same cycle after reset -> A owns; A drops -> TURN 1 cycle -> B owns (grant=10); b_read_rdy=0 throughout A ownership.
REQ-035 B owns, A requests, B releases, both re-request together -> A wins (round robin).
REQ-036 TIMEOUT_CYCLES=8, A holds write_mode -> grant drops after 8 owner cycles, timeout_err=1, A not re-granted until write_mode low one cycle; timeout_clr clears flag.
REQ-037 resetb pulsed low during B write with di_write=1 -> di_write=0 and grant=00 immediately, all outputs at reset values.
